// File: rtl/cache_axi_bridge.sv
// Cache miss/writeback request port to AXI 32-bit master bridge: one outstanding read, one outstanding write.
// Optional sticky AXI error reporting is enabled by defining BRIDGE_RESP_ERR_EN.
module cache_axi_bridge #(
  parameter logic [3:0] RD_ID = 4'd0,
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic         data_write_ok,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [3:0]   wid,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
`ifdef BRIDGE_RESP_ERR_EN
  ,
  output logic         resp_err,
  output logic [1:0]   resp_err_code
`endif
);

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_DATA = 2'd2} rd_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_AW = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} wr_state_t;

  rd_state_t    rd_state_r, rd_state_s;
  wr_state_t    wr_state_r, wr_state_s;
  logic [31:0]  rd_addr_r;
  logic [2:0]   rd_type_r;
  logic [31:0]  wr_addr_r;
  logic [2:0]   wr_type_r;
  logic [3:0]   wr_wstrb_r;
  logic [127:0] wr_data_r;
  logic [1:0]   beat_r;
  logic         hazard_s;
  logic         rd_line_s;
  logic         wr_line_s;
  logic         unused_s;

  assign unused_s = ^{rid, bid, rresp, bresp};

  // A read to a line with a write in flight (or being accepted now) waits for the B response.
  assign hazard_s = ((wr_state_r != W_IDLE) && (rd_addr[31:4] == wr_addr_r[31:4])) ||
                    (wr_req && wr_rdy && (rd_addr[31:4] == wr_addr[31:4]));

  assign rd_line_s = (rd_type_r == 3'd4);
  assign wr_line_s = (wr_type_r == 3'd4);

  assign arid    = RD_ID;
  assign araddr  = rd_line_s ? {rd_addr_r[31:4], 4'd0} : rd_addr_r;
  assign arlen   = rd_line_s ? 8'd3 : 8'd0;
  assign arsize  = rd_line_s ? 3'd2 : {1'b0, rd_type_r[1:0]};
  assign arburst = 2'b01;

  assign ret_valid = rvalid && rready;
  assign ret_data  = rdata;
  assign ret_last  = rlast;

  assign awid    = WR_ID;
  assign awaddr  = wr_line_s ? {wr_addr_r[31:4], 4'd0} : wr_addr_r;
  assign awlen   = wr_line_s ? 8'd3 : 8'd0;
  assign awsize  = wr_line_s ? 3'd2 : {1'b0, wr_type_r[1:0]};
  assign awburst = 2'b01;
  assign wid     = WR_ID;
  assign wdata   = wr_data_r[{beat_r, 5'd0} +: 32];
  assign wstrb   = wr_line_s ? 4'hf : wr_wstrb_r;
  assign wlast   = (beat_r == awlen[1:0]);

  // Read FSM state register and request buffer.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_state_r <= R_IDLE;
      rd_addr_r  <= 32'd0;
      rd_type_r  <= 3'd0;
    end else begin
      rd_state_r <= rd_state_s;
      if ((rd_state_r == R_IDLE) && rd_req && rd_rdy) begin
        rd_addr_r <= rd_addr;
        rd_type_r <= rd_type;
      end
    end
  end

  // Read FSM next state and handshake outputs.
  always_comb begin
    rd_state_s = rd_state_r;
    rd_rdy     = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    case (rd_state_r)
      R_IDLE: begin
        rd_rdy = !hazard_s;
        if (rd_req && !hazard_s) rd_state_s = R_AR;
        else                     rd_state_s = R_IDLE;
      end
      R_AR: begin
        arvalid = 1'b1;
        if (arready) rd_state_s = R_DATA;
        else         rd_state_s = R_AR;
      end
      R_DATA: begin
        rready = 1'b1;
        if (rvalid && rlast) rd_state_s = R_IDLE;
        else                 rd_state_s = R_DATA;
      end
      default: rd_state_s = R_IDLE;
    endcase
  end

  // Write FSM state register, line buffer and beat counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_state_r <= W_IDLE;
      wr_addr_r  <= 32'd0;
      wr_type_r  <= 3'd0;
      wr_wstrb_r <= 4'd0;
      wr_data_r  <= 128'd0;
      beat_r     <= 2'd0;
    end else begin
      wr_state_r <= wr_state_s;
      if ((wr_state_r == W_IDLE) && wr_req) begin
        wr_addr_r  <= wr_addr;
        wr_type_r  <= wr_type;
        wr_wstrb_r <= wr_wstrb;
        wr_data_r  <= wr_data;
        beat_r     <= 2'd0;
      end else if (wvalid && wready) begin
        beat_r <= beat_r + 2'd1;
      end
    end
  end

  // Write FSM next state and handshake outputs.
  always_comb begin
    wr_state_s    = wr_state_r;
    wr_rdy        = 1'b0;
    awvalid       = 1'b0;
    wvalid        = 1'b0;
    bready        = 1'b0;
    data_write_ok = 1'b0;
    case (wr_state_r)
      W_IDLE: begin
        wr_rdy = 1'b1;
        if (wr_req) wr_state_s = W_AW;
        else        wr_state_s = W_IDLE;
      end
      W_AW: begin
        awvalid = 1'b1;
        if (awready) wr_state_s = W_DATA;
        else         wr_state_s = W_AW;
      end
      W_DATA: begin
        wvalid = 1'b1;
        if (wready && wlast) wr_state_s = W_RESP;
        else                 wr_state_s = W_DATA;
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          data_write_ok = 1'b1;
          wr_state_s    = W_IDLE;
        end else begin
          wr_state_s = W_RESP;
        end
      end
      default: wr_state_s = W_IDLE;
    endcase
  end

`ifdef BRIDGE_RESP_ERR_EN
  logic       resp_err_r;
  logic [1:0] resp_err_code_r;

  assign resp_err      = resp_err_r;
  assign resp_err_code = resp_err_code_r;

  // Sticky capture of the first non-OKAY response; R wins a same-cycle tie.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      resp_err_r      <= 1'b0;
      resp_err_code_r <= 2'd0;
    end else if (!resp_err_r) begin
      if (rvalid && rready && (rresp != 2'd0)) begin
        resp_err_r      <= 1'b1;
        resp_err_code_r <= rresp;
      end else if (bvalid && bready && (bresp != 2'd0)) begin
        resp_err_r      <= 1'b1;
        resp_err_code_r <= bresp;
      end
    end
  end
`endif

endmodule
